// File: rtl/fp_align_pipe.sv
// fp_align_pipe -- two-stage floating-point operand alignment pipeline.
//
// Takes an operand pair (sign, biased exponent, mantissa with hidden bit)
// plus an add/subtract opcode. It orders the pair by magnitude and shifts
// the smaller mantissa right so that both share the larger exponent. The
// shifted mantissa carries guard/round/sticky bits.
//
//   S1 (compare/swap): registers the large/small operands, the exponent
//                      difference d, the effective-subtract flag and the
//                      result sign.
//   S2 (shift/sticky): performs the alignment shift and drives the outputs.
//
// Ports
//   I_Clk, I_Reset                      clock, asynchronous active-high reset
//   I_Valid / O_Ready                   input handshake
//   I_Op                                0 = add, 1 = subtract (op1 - op2)
//   I_Sign_Op*, I_Exp_Op*, I_Mantissa_Op*  operand fields (E / M+1 bits)
//   O_Valid / I_Ready                   output handshake
//   O_Exp, O_Sign, O_Eff_Sub, O_Swap    aligned result descriptors
//   O_Mant_Large                        {larger mantissa, 3'b000}
//   O_Mant_Small                        {aligned smaller mantissa, G, R, S}
module fp_align_pipe #(
  parameter int PRECISION = 32,
  parameter int GRS_EN    = 1,
  localparam int E = (PRECISION == 16) ? 5  : (PRECISION == 64) ? 11 : 8,
  localparam int M = (PRECISION == 16) ? 10 : (PRECISION == 64) ? 52 : 23,
  localparam int W = M + 4
) (
  input  logic         I_Clk,
  input  logic         I_Reset,
  input  logic         I_Valid,
  output logic         O_Ready,
  input  logic         I_Op,
  input  logic         I_Sign_Op1,
  input  logic         I_Sign_Op2,
  input  logic [E-1:0] I_Exp_Op1,
  input  logic [E-1:0] I_Exp_Op2,
  input  logic [M:0]   I_Mantissa_Op1,
  input  logic [M:0]   I_Mantissa_Op2,
  output logic         O_Valid,
  input  logic         I_Ready,
  output logic [E-1:0] O_Exp,
  output logic         O_Sign,
  output logic         O_Eff_Sub,
  output logic         O_Swap,
  output logic [W-1:0] O_Mant_Large,
  output logic [W-1:0] O_Mant_Small
);

  // Stage 1 state
  logic         s1_valid_q, s1_valid_d;
  logic [E-1:0] s1_exp_l_q, s1_exp_l_d;
  logic [E-1:0] s1_d_q, s1_d_d;
  logic [M:0]   s1_mant_l_q, s1_mant_l_d;
  logic [M:0]   s1_mant_s_q, s1_mant_s_d;
  logic         s1_eff_sub_q, s1_eff_sub_d;
  logic         s1_sign_q, s1_sign_d;
  logic         s1_swap_q, s1_swap_d;

  // Stage 2 state (drives the outputs directly)
  logic         s2_valid_q, s2_valid_d;
  logic [E-1:0] s2_exp_q, s2_exp_d;
  logic         s2_sign_q, s2_sign_d;
  logic         s2_eff_sub_q, s2_eff_sub_d;
  logic         s2_swap_q, s2_swap_d;
  logic [W-1:0] s2_mant_l_q, s2_mant_l_d;
  logic [W-1:0] s2_mant_s_q, s2_mant_s_d;

  logic s1_load, s2_load;
  logic swap_c;

  // A stage loads when it is empty or when its successor loads this cycle.
  assign s2_load = ~s2_valid_q | I_Ready;
  assign s1_load = ~s1_valid_q | s2_load;
  assign O_Ready = s1_load;

  // Equal exponent and equal mantissa leaves the operands in place.
  assign swap_c = (I_Exp_Op2 > I_Exp_Op1) ||
                  ((I_Exp_Op2 == I_Exp_Op1) && (I_Mantissa_Op2 > I_Mantissa_Op1));

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_exp_l_d   = s1_exp_l_q;
    s1_d_d       = s1_d_q;
    s1_mant_l_d  = s1_mant_l_q;
    s1_mant_s_d  = s1_mant_s_q;
    s1_eff_sub_d = s1_eff_sub_q;
    s1_sign_d    = s1_sign_q;
    s1_swap_d    = s1_swap_q;
    if (s1_load) begin
      s1_valid_d = I_Valid;
      // Data only changes on a real transfer, so idle cycles keep it quiet.
      if (I_Valid) begin
        s1_swap_d    = swap_c;
        s1_eff_sub_d = I_Sign_Op1 ^ I_Sign_Op2 ^ I_Op;
        if (swap_c) begin
          s1_exp_l_d  = I_Exp_Op2;
          s1_d_d      = I_Exp_Op2 - I_Exp_Op1;
          s1_mant_l_d = I_Mantissa_Op2;
          s1_mant_s_d = I_Mantissa_Op1;
          s1_sign_d   = I_Sign_Op2 ^ I_Op;
        end else begin
          s1_exp_l_d  = I_Exp_Op1;
          s1_d_d      = I_Exp_Op1 - I_Exp_Op2;
          s1_mant_l_d = I_Mantissa_Op1;
          s1_mant_s_d = I_Mantissa_Op2;
          s1_sign_d   = I_Sign_Op1;
        end
      end
    end
  end

  // Alignment shift. The difference is zero-extended to 32 bits before
  // shifting, so a large d never wraps. Once d >= W the shifted value is
  // zero and the lost-bit mask covers the whole field, which reduces the
  // result to a lone sticky bit equal to |mant_s with no special case.
  logic [31:0]  d_ext;
  logic [W-1:0] ext, shifted, lost_mask, small_c;
  logic         sticky;

  always_comb begin
    d_ext     = {{(32-E){1'b0}}, s1_d_q};
    ext       = {s1_mant_s_q, 3'b000};
    shifted   = ext >> d_ext;
    lost_mask = ~({W{1'b1}} << d_ext);
    sticky    = |(ext & lost_mask);
    small_c   = {shifted[W-1:1], shifted[0] | sticky};
    if (GRS_EN == 0) small_c[2:0] = 3'b000;
  end

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_exp_d     = s2_exp_q;
    s2_sign_d    = s2_sign_q;
    s2_eff_sub_d = s2_eff_sub_q;
    s2_swap_d    = s2_swap_q;
    s2_mant_l_d  = s2_mant_l_q;
    s2_mant_s_d  = s2_mant_s_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_exp_d     = s1_exp_l_q;
        s2_sign_d    = s1_sign_q;
        s2_eff_sub_d = s1_eff_sub_q;
        s2_swap_d    = s1_swap_q;
        s2_mant_l_d  = {s1_mant_l_q, 3'b000};
        s2_mant_s_d  = small_c;
      end
    end
  end

  always_ff @(posedge I_Clk or posedge I_Reset) begin
    if (I_Reset) begin
      s1_valid_q   <= 1'b0;
      s1_exp_l_q   <= '0;
      s1_d_q       <= '0;
      s1_mant_l_q  <= '0;
      s1_mant_s_q  <= '0;
      s1_eff_sub_q <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_swap_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_exp_q     <= '0;
      s2_sign_q    <= 1'b0;
      s2_eff_sub_q <= 1'b0;
      s2_swap_q    <= 1'b0;
      s2_mant_l_q  <= '0;
      s2_mant_s_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_exp_l_q   <= s1_exp_l_d;
      s1_d_q       <= s1_d_d;
      s1_mant_l_q  <= s1_mant_l_d;
      s1_mant_s_q  <= s1_mant_s_d;
      s1_eff_sub_q <= s1_eff_sub_d;
      s1_sign_q    <= s1_sign_d;
      s1_swap_q    <= s1_swap_d;
      s2_valid_q   <= s2_valid_d;
      s2_exp_q     <= s2_exp_d;
      s2_sign_q    <= s2_sign_d;
      s2_eff_sub_q <= s2_eff_sub_d;
      s2_swap_q    <= s2_swap_d;
      s2_mant_l_q  <= s2_mant_l_d;
      s2_mant_s_q  <= s2_mant_s_d;
    end
  end

  assign O_Valid      = s2_valid_q;
  assign O_Exp        = s2_exp_q;
  assign O_Sign       = s2_sign_q;
  assign O_Eff_Sub    = s2_eff_sub_q;
  assign O_Swap       = s2_swap_q;
  assign O_Mant_Large = s2_mant_l_q;
  assign O_Mant_Small = s2_mant_s_q;

endmodule
